rfblackwidow_pregfile: RTL and testbench

Predicate register file for the BlackWidow core: the write/storage end of the predicate path, whose read outputs feed the per-operand predicate forwarding muxes. It holds 64 one-bit predicates (p0 reads 0, p1 reads 1), commits compare results from writeback as a result/complement pair, and tracks in-flight writes with a per-register busy scoreboard. A drain-then-load restore sequence reloads all predicates on context switch.

---
 rtl/rfblackwidow_pregfile_pkg.sv | 24 ++
 rtl/rfblackwidow_pregfile_if.sv | 38 +++
 rtl/rfblackwidow_pregfile_pscoreboard.sv | 40 ++++
 rtl/rfblackwidow_pregfile.sv | 121 ++++++++++++
 tb/tb_rfblackwidow_pregfile.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rfblackwidow_pregfile_pkg.sv
// Shared types and helpers for the BlackWidow predicate register file.
package rfblackwidow_pregfile_pkg;

    localparam int NPREG   = 64;
    localparam int PREG_LO = 2;    // p0/p1 are hardwired, storage starts at p2

    typedef logic [5:0] pregno_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_DRAIN,
        PS_LOAD
    } pstate_t;

    // One-hot select of a writable predicate; p0/p1 never decode.
    function automatic logic [NPREG-1:0] preg_dec(input logic en, input pregno_t r);
        logic [NPREG-1:0] m;
        m = '0;
        if (en) m[r] = 1'b1;
        m[PREG_LO-1:0] = '0;
        return m;
    endfunction

endpackage

// File: rtl/rfblackwidow_pregfile_if.sv
// Issue/writeback/read/restore bundle of the predicate register file.
interface rfblackwidow_pregfile_if #(
    parameter int NRDPORT = 3
);
    import rfblackwidow_pregfile_pkg::*;

    logic                     iss_v;
    pregno_t                  iss_pRt1;
    pregno_t                  iss_pRt2;
    logic                     wprfwr;
    pregno_t                  wpRt1;
    pregno_t                  wpRt2;
    logic                     wpres;
    pregno_t [NRDPORT-1:0]    pRn;
    logic    [NRDPORT-1:0]    prfo;
    logic    [NRDPORT-1:0]    pbusy;
    logic    [NPREG-1:0]      snap;
    logic                     restore_req;
    logic    [NPREG-1:0]      restore_dat;
    logic                     restore_ack;

    modport master (
        output iss_v, iss_pRt1, iss_pRt2,
        output wprfwr, wpRt1, wpRt2, wpres,
        output pRn,
        output restore_req, restore_dat,
        input  prfo, pbusy, snap, restore_ack
    );

    modport slave (
        input  iss_v, iss_pRt1, iss_pRt2,
        input  wprfwr, wpRt1, wpRt2, wpres,
        input  pRn,
        input  restore_req, restore_dat,
        output prfo, pbusy, snap, restore_ack
    );

endinterface

// File: rtl/rfblackwidow_pregfile_pscoreboard.sv
// Per-predicate in-flight write scoreboard: issue sets, writeback clears.
module rfblackwidow_pregfile_pscoreboard
    import rfblackwidow_pregfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_v,
    input  pregno_t          set_a,
    input  pregno_t          set_b,
    input  logic             clr_v,
    input  pregno_t          clr_a,
    input  pregno_t          clr_b,
    output logic [NPREG-1:0] busy,
    output logic             any_busy
);

    logic [NPREG-1:0] busy_d;
    logic [NPREG-1:0] busy_q;
    logic [NPREG-1:0] set_m;
    logic [NPREG-1:0] clr_m;

    // A same-cycle set and clear of one register leaves it busy.
    always_comb begin
        set_m  = preg_dec(set_v, set_a) | preg_dec(set_v, set_b);
        clr_m  = preg_dec(clr_v, clr_a) | preg_dec(clr_v, clr_b);
        busy_d = (busy_q & ~clr_m) | set_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/rfblackwidow_pregfile.sv
// Predicate register file with result/complement writeback and drain-then-load restore.
// Busy tracking is built only when PREG_SCOREBOARD_EN is defined.
module rfblackwidow_pregfile
    import rfblackwidow_pregfile_pkg::*;
#(
    parameter int NRDPORT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rfblackwidow_pregfile_if.slave pif
);

    pstate_t                  state_d;
    pstate_t                  state_q;
    logic                     ack_d;
    logic                     ack_q;
    logic [NPREG-1:PREG_LO]   preg_d;
    logic [NPREG-1:PREG_LO]   preg_q;
    logic [NPREG-1:0]         wr1_m;
    logic [NPREG-1:0]         wr2_m;
    logic [NPREG-1:0]         preg_all;
    logic [NPREG-1:0]         busy_all;
    logic                     any_busy;
    logic                     unused_rdat;

    // pRt1 is applied last so it wins when both destinations coincide;
    // a LOAD cycle then overrides any writeback.
    always_comb begin
        wr1_m  = preg_dec(pif.wprfwr, pif.wpRt1);
        wr2_m  = preg_dec(pif.wprfwr, pif.wpRt2);
        preg_d = preg_q;
        for (int n = PREG_LO; n < NPREG; n++) begin
            if (wr2_m[n]) preg_d[n] = ~pif.wpres;
            if (wr1_m[n]) preg_d[n] = pif.wpres;
        end
        if (state_q == PS_LOAD) begin
            preg_d = pif.restore_dat[NPREG-1:PREG_LO];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preg_q <= '0;
        end else begin
            preg_q <= preg_d;
        end
    end

    // restore_ack is registered and is high exactly while in PS_LOAD.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        unique case (state_q)
            PS_IDLE: begin
                if (pif.restore_req) state_d = PS_DRAIN;
            end
            PS_DRAIN: begin
                if (!pif.restore_req) begin
                    state_d = PS_IDLE;
                end else if (!any_busy) begin
                    state_d = PS_LOAD;
                    ack_d   = 1'b1;
                end
            end
            PS_LOAD: begin
                state_d = PS_IDLE;
            end
            default: begin
                state_d = PS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

`ifdef PREG_SCOREBOARD_EN
    logic iss_ok;

    // Issue is stalled upstream during a drain; ignore any stray request.
    assign iss_ok = pif.iss_v & (state_q != PS_DRAIN);

    rfblackwidow_pregfile_pscoreboard u_pscoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_v    (iss_ok),
        .set_a    (pif.iss_pRt1),
        .set_b    (pif.iss_pRt2),
        .clr_v    (pif.wprfwr),
        .clr_a    (pif.wpRt1),
        .clr_b    (pif.wpRt2),
        .busy     (busy_all),
        .any_busy (any_busy)
    );
`else
    logic unused_iss;

    assign busy_all   = '0;
    assign any_busy   = 1'b0;
    assign unused_iss = ^{pif.iss_v, pif.iss_pRt1, pif.iss_pRt2};
`endif

    assign unused_rdat = ^pif.restore_dat[PREG_LO-1:0];
    assign preg_all    = {preg_q, 2'b10};

    for (genvar i = 0; i < NRDPORT; i++) begin : g_rd
        assign pif.prfo[i]  = preg_all[pif.pRn[i]];
        assign pif.pbusy[i] = busy_all[pif.pRn[i]];
    end

    assign pif.snap        = preg_all;
    assign pif.restore_ack = ack_q;

endmodule

// File: tb/tb_rfblackwidow_pregfile.sv
// Directed bench for the predicate register file (both scoreboard builds).
module tb_rfblackwidow_pregfile;
    import rfblackwidow_pregfile_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    rfblackwidow_pregfile_if #(.NRDPORT(3)) pif ();

    rfblackwidow_pregfile #(.NRDPORT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd3(input pregno_t a, input pregno_t b, input pregno_t c);
        pif.pRn[0] = a;
        pif.pRn[1] = b;
        pif.pRn[2] = c;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb(input pregno_t r1, input pregno_t r2, input logic res);
        pif.wprfwr = 1'b1;
        pif.wpRt1  = r1;
        pif.wpRt2  = r2;
        pif.wpres  = res;
    endtask

    initial begin
        rst_n           = 1'b0;
        pif.iss_v       = 1'b0;
        pif.iss_pRt1    = '0;
        pif.iss_pRt2    = '0;
        pif.wprfwr      = 1'b0;
        pif.wpRt1       = '0;
        pif.wpRt2       = '0;
        pif.wpres       = 1'b0;
        pif.pRn         = '0;
        pif.restore_req = 1'b0;
        pif.restore_dat = '0;

        // Reset state
        repeat (2) step();
        rst_n = 1'b1;
        step();
        rd3(6'd0, 6'd1, 6'd5);
        chk("rst_prfo", 64'(pif.prfo), 64'b010);
        chk("rst_pbusy", 64'(pif.pbusy), 64'b000);
        chk("rst_ack", 64'(pif.restore_ack), 64'd0);
        chk("rst_snap", pif.snap, 64'h2);

        // Result/complement pair
        wb(6'd5, 6'd6, 1'b1);
        step();
        pif.wprfwr = 1'b0;
        rd3(6'd5, 6'd6, 6'd0);
        chk("wb_pair_prfo", 64'(pif.prfo), 64'b001);
        chk("wb_pair_snap", pif.snap, 64'h22);

        // Same destination: pRt1 wins
        wb(6'd7, 6'd7, 1'b0);
        step();
        wb(6'd8, 6'd8, 1'b1);
        step();
        pif.wprfwr = 1'b0;
        rd3(6'd7, 6'd8, 6'd5);
        chk("wb_same_prfo", 64'(pif.prfo), 64'b110);
        chk("wb_same_snap", pif.snap, 64'h122);

        // Writes to p0/p1 are discarded
        wb(6'd0, 6'd1, 1'b1);
        step();
        wb(6'd1, 6'd0, 1'b0);
        step();
        pif.wprfwr = 1'b0;
        rd3(6'd0, 6'd1, 6'd8);
        chk("wb_p01_prfo", 64'(pif.prfo), 64'b110);
        chk("wb_p01_snap", pif.snap, 64'h122);

        // Overwrite with swapped pair
        wb(6'd6, 6'd5, 1'b1);
        step();
        pif.wprfwr = 1'b0;
        rd3(6'd5, 6'd6, 6'd7);
        chk("wb_swap_prfo", 64'(pif.prfo), 64'b010);
        chk("wb_swap_snap", pif.snap, 64'h142);

        // Scoreboard set, and set-wins against same-cycle clear
        pif.iss_v    = 1'b1;
        pif.iss_pRt1 = 6'd9;
        pif.iss_pRt2 = 6'd10;
        step();
        pif.iss_v = 1'b0;
        rd3(6'd9, 6'd10, 6'd11);
`ifdef PREG_SCOREBOARD_EN
        chk("sb_set", 64'(pif.pbusy), 64'b011);
`else
        chk("sb_off_set", 64'(pif.pbusy), 64'b000);
`endif
        pif.iss_v    = 1'b1;
        pif.iss_pRt1 = 6'd9;
        pif.iss_pRt2 = 6'd9;
        wb(6'd9, 6'd10, 1'b1);
        step();
        pif.iss_v  = 1'b0;
        pif.wprfwr = 1'b0;
        rd3(6'd9, 6'd10, 6'd11);
`ifdef PREG_SCOREBOARD_EN
        chk("sb_setwins", 64'(pif.pbusy), 64'b001);
`else
        chk("sb_off_setwins", 64'(pif.pbusy), 64'b000);
`endif
        chk("sb_wb_prfo", 64'(pif.prfo), 64'b001);

        // Restore with all-ones image
        pif.restore_req = 1'b1;
        pif.restore_dat = '1;
        step();
        chk("rs_drain_ack", 64'(pif.restore_ack), 64'd0);
`ifdef PREG_SCOREBOARD_EN
        pif.iss_v    = 1'b1;
        pif.iss_pRt1 = 6'd40;
        pif.iss_pRt2 = 6'd40;
        step();
        pif.iss_v = 1'b0;
        chk("rs_wait_ack0", 64'(pif.restore_ack), 64'd0);
        repeat (2) begin
            step();
            chk("rs_wait_ack", 64'(pif.restore_ack), 64'd0);
        end
        wb(6'd9, 6'd9, 1'b0);
        step();
        pif.wprfwr = 1'b0;
        chk("rs_clr_ack", 64'(pif.restore_ack), 64'd0);
        rd3(6'd9, 6'd40, 6'd0);
        chk("rs_clr_pbusy", 64'(pif.pbusy), 64'b000);
        chk("rs_clr_prfo", 64'(pif.prfo), 64'b000);
`endif
        step();
        chk("rs_load_ack", 64'(pif.restore_ack), 64'd1);
        pif.restore_req = 1'b0;
        wb(6'd20, 6'd21, 1'b0);
        step();
        pif.wprfwr = 1'b0;
        chk("rs_done_ack", 64'(pif.restore_ack), 64'd0);
        chk("rs_snap", pif.snap, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        chk("rs_idle_ack", 64'(pif.restore_ack), 64'd0);

        // Reset during DRAIN
        pif.iss_v    = 1'b1;
        pif.iss_pRt1 = 6'd30;
        pif.iss_pRt2 = 6'd30;
        step();
        pif.iss_v       = 1'b0;
        pif.restore_req = 1'b1;
        step();
        rst_n = 1'b0;
        pif.restore_req = 1'b0;
        rd3(6'd30, 6'd1, 6'd2);
        chk("rd_rst_ack", 64'(pif.restore_ack), 64'd0);
        chk("rd_rst_pbusy", 64'(pif.pbusy), 64'b000);
        chk("rd_rst_snap", pif.snap, 64'h2);
        step();
        rst_n = 1'b1;
        repeat (2) begin
            step();
            chk("rd_post_ack", 64'(pif.restore_ack), 64'd0);
        end

        // Minimum-latency restore with a sparse image
        pif.restore_req = 1'b1;
        pif.restore_dat = 64'h8000_0000_0000_0013;
        step();
        chk("ml_drain_ack", 64'(pif.restore_ack), 64'd0);
        step();
        chk("ml_load_ack", 64'(pif.restore_ack), 64'd1);
        pif.restore_req = 1'b0;
        step();
        chk("ml_done_ack", 64'(pif.restore_ack), 64'd0);
        chk("ml_snap", pif.snap, 64'h8000_0000_0000_0012);
        rd3(6'd63, 6'd4, 6'd0);
        chk("ml_prfo", 64'(pif.prfo), 64'b011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
